multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multicycle control unit for the RV32I core. A Moore state machine sequences fetch, decode, execute, memory and writeback over shared ALU, memory and immediate-extension resources. It drives the immediate-extender select (immsrc), ALU operand muxes, result mux, address mux and all write enables. It also holds the machine in memory states until the memory handshake completes.

Parameters:
RESET_STATE, 4'd0 (FETCH), state entered on reset
ILLEGAL_TRAP, 1, 1 = unknown opcode goes to ILLEGAL state; 0 = treated as NOP (back to FETCH)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
immsrc  output  2  extender select: 00 I, 01 S, 10 B, 11 J
alusrca  output  2  00 PC, 01 oldPC, 10 rs1 data
alusrcb  output  2  00 rs2 data, 01 immext, 10 constant 4
resultsrc  output  2  00 ALUOut, 01 memory data, 10 ALU result
adrsrc  output  1  0 PC, 1 result (data address)
alucontrol  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
irwrite  output  1  load IR and oldPC
pcwrite  output  1  load PC
regwrite  output  1  register-file write
memwrite  output  1  data-memory write
illegal  output  1  one-cycle pulse on unknown opcode

Behaviour:
- State register is 4-bit, asynchronously reset to FETCH. While rst_n=0, irwrite, pcwrite, regwrite, memwrite and illegal are forced to 0.
- After reset, the remaining outputs equal their FETCH values.
- immsrc is purely combinational from op:
  - 0000011, 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - any other op -> 00
- Other outputs decode from the state register only (Moore), except pcwrite in BEQ and the mem_ready gating below. Unlisted outputs are 0.
- FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=add, resultsrc=10. irwrite=pcwrite=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alusrca=01, alusrcb=01, add (branch target into ALUOut). Next state by op:
  - lw/sw -> MEMADR
  - R-type 0110011 -> EXECUTER
  - I-ALU 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - otherwise -> ILLEGAL (or FETCH if ILLEGAL_TRAP=0)
- MEMADR: alusrca=10, alusrcb=01, add. Next is MEMREAD for op 0000011, MEMWRITE for 0100011.
- MEMREAD: adrsrc=1, resultsrc=00. Wait for mem_ready, then go to MEMWB.
- MEMWB: resultsrc=01, regwrite=1, then FETCH.
- MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1 held every cycle until mem_ready, then FETCH.
- EXECUTER: alusrca=10, alusrcb=00, ALU decoded from funct. Then ALUWB.
- EXECUTEI: alusrca=10, alusrcb=01, ALU decoded from funct. Then ALUWB.
- ALUWB: resultsrc=00, regwrite=1, then FETCH.
- BEQ: alusrca=10, alusrcb=00, sub, resultsrc=00. pcwrite = zero for funct3=000 and ~zero for funct3=001; other funct3 gives pcwrite=0. Then FETCH.
- JAL: alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1, then ALUWB (writes PC+4 to rd).
- ILLEGAL: illegal=1 for one cycle, no write enables, then FETCH.
- ALU decode, funct mode (EXECUTER/EXECUTEI):
  - funct3 000: sub if op[5]&funct7b5, else add
  - funct3 010: slt
  - funct3 110: or
  - funct3 111: and
  - other funct3: add
- Cycle counts with mem_ready tied to 1:
  - R/I-ALU: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - jal: 4
- Asynchronous reset mid-instruction: state returns to FETCH immediately and write enables drop in the same cycle. No partial write is committed after reset release.
- Unused state encodings (12-15) go to FETCH on the next clock.

Decomposition:
- Shared package: state encodings, opcode constants, immsrc codes, alucontrol codes and alusrca/alusrcb/resultsrc encodings. The extender and datapath import the same package.
- One sub-module: alu_decoder (combinational; aluop, funct3, funct7b5, op5 -> alucontrol).
- The FSM and the immsrc decode stay in multicycle_ctrl.

Test Plan:
- Reset: hold rst_n=0 mid-MEMWRITE -> memwrite=0 immediately. After release, state is FETCH with alusrcb=10 and resultsrc=10.
- add x3,x1,x2 (op 0110011, funct3 000, funct7b5 0), mem_ready=1 -> sequence FETCH, DECODE, EXECUTER (alucontrol 000), ALUWB (regwrite=1). Total 4 cycles. Repeat with funct7b5=1 -> alucontrol 001.
- lw (op 0000011) with mem_ready low 3 cycles in MEMREAD -> adrsrc=1 held 4 cycles, then MEMWB regwrite=1 once. immsrc=00 throughout.
- sw (op 0100011), mem_ready=1 -> immsrc=01, memwrite=1 exactly one cycle, regwrite never asserted.
- beq with zero=1, then bne with zero=1:
  - beq -> immsrc=10, pcwrite=1 in BEQ.
  - bne -> pcwrite=0.
- jal (op 1101111) -> immsrc=11, pcwrite=1 in JAL, then ALUWB regwrite=1. op=1111111 -> illegal pulses one cycle, no write enables, back to FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes and
// datapath mux/ALU select codes used by the controller, extender and datapath.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // Extender select depends only on the opcode, never on the FSM state.
   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      logic [1:0] sel;
      sel = IMM_I;
      case (op)
         OP_STORE:  sel = IMM_S;
         OP_BRANCH: sel = IMM_B;
         OP_JAL:    sel = IMM_J;
         default:   sel = IMM_I;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, mux selects
// and write enables out, plus the current FSM state for observation.
interface multicycle_ctrl_if;
   import multicycle_ctrl_pkg::*;

   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   // Memory handshake: the controller presents an access (fetch, load or store)
   // and holds it with all selects stable; the access completes on the cycle
   // mem_ready=1, and only then does the FSM advance or commit its write.
   logic       mem_ready;

   logic [1:0] immsrc;
   logic [1:0] alusrca;
   logic [1:0] alusrcb;
   logic [1:0] resultsrc;
   logic       adrsrc;
   logic [2:0] alucontrol;
   logic       irwrite;
   logic       pcwrite;
   logic       regwrite;
   logic       memwrite;
   logic       illegal;
   state_t     state_dbg;

   modport master (
      output op, funct3, funct7b5, zero, mem_ready,
      input  immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
      input  irwrite, pcwrite, regwrite, memwrite, illegal, state_dbg
   );

   modport slave (
      input  op, funct3, funct7b5, zero, mem_ready,
      output immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
      output irwrite, pcwrite, regwrite, memwrite, illegal, state_dbg
   );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode: fixed add/sub for address and branch states, funct3 /
// funct7b5 decode for R-type and I-type ALU instructions.
module multicycle_ctrl_alu_decoder
   import multicycle_ctrl_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // op5 separates R-type from I-type: addi has no subtract form.
               3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol = ALU_SLT;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback for the RV32I
// multicycle core; write enables are gated off while reset is asserted.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter state_t RESET_STATE  = S_FETCH,
   parameter bit     ILLEGAL_TRAP = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   multicycle_ctrl_if.slave bus
);

   state_t     state_q, state_d;
   aluop_t     aluop;
   logic [1:0] alusrca, alusrcb, resultsrc;
   logic       adrsrc;
   logic       irwrite, pcwrite, regwrite, memwrite, illegal;
   logic [2:0] alucontrol;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RESET_STATE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = S_FETCH;
      aluop     = ALUOP_ADD;
      alusrca   = SRCA_PC;
      alusrcb   = SRCB_RS2;
      resultsrc = RES_ALUOUT;
      adrsrc    = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrcb   = SRCB_FOUR;
            resultsrc = RES_ALU;
            irwrite   = bus.mem_ready;
            pcwrite   = bus.mem_ready;
            state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrca = SRCA_OLDPC;
            alusrcb = SRCB_IMM;
            case (bus.op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               default:           state_d = ILLEGAL_TRAP ? S_ILLEGAL : S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_IMM;
            if (bus.op == OP_LOAD)       state_d = S_MEMREAD;
            else if (bus.op == OP_STORE) state_d = S_MEMWRITE;
            else                         state_d = S_FETCH;
         end
         S_MEMREAD: begin
            adrsrc  = 1'b1;
            state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            resultsrc = RES_MEM;
            regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            state_d  = bus.mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            alusrca = SRCA_RS1;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_IMM;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: regwrite = 1'b1;
         S_BEQ: begin
            alusrca = SRCA_RS1;
            aluop   = ALUOP_SUB;
            case (bus.funct3)
               3'b000:  pcwrite = bus.zero;
               3'b001:  pcwrite = ~bus.zero;
               default: pcwrite = 1'b0;
            endcase
         end
         S_JAL: begin
            alusrca = SRCA_OLDPC;
            alusrcb = SRCB_FOUR;
            pcwrite = 1'b1;
            state_d = S_ALUWB;
         end
         S_ILLEGAL: illegal = 1'b1;
         default:   state_d = S_FETCH;
      endcase
   end

   multicycle_ctrl_alu_decoder u_alu_decoder (
      .aluop      (aluop),
      .funct3     (bus.funct3),
      .funct7b5   (bus.funct7b5),
      .op5        (bus.op[5]),
      .alucontrol (alucontrol)
   );

   assign bus.immsrc     = imm_sel(bus.op);
   assign bus.alusrca    = alusrca;
   assign bus.alusrcb    = alusrcb;
   assign bus.resultsrc  = resultsrc;
   assign bus.adrsrc     = adrsrc;
   assign bus.alucontrol = alucontrol;
   // The state register resets asynchronously, but FETCH's irwrite/pcwrite
   // follow mem_ready, so enables are also masked combinationally by rst_n.
   assign bus.irwrite    = irwrite  & rst_n;
   assign bus.pcwrite    = pcwrite  & rst_n;
   assign bus.regwrite   = regwrite & rst_n;
   assign bus.memwrite   = memwrite & rst_n;
   assign bus.illegal    = illegal  & rst_n;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each step pushes the expected control
// vector for the cycle into a queue and pops/compares it before the next edge.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   logic [20:0] exp_q[$];

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, observed running expected finished");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic op5, input logic f7);
      case (f3)
         3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Vector layout: {state, immsrc, alusrca, alusrcb, resultsrc, adrsrc,
   //                 alucontrol, irwrite, pcwrite, regwrite, memwrite, illegal}
   function automatic logic [20:0] model(input state_t st, input logic mr, input logic rst_ok);
      logic [1:0] imm, sa, sb, rs;
      logic       adr;
      logic [2:0] alu;
      logic       irw, pcw, rw, mw, ill;
      imm = 2'b00; sa = 2'b00; sb = 2'b00; rs = 2'b00; adr = 1'b0; alu = 3'b000;
      irw = 1'b0; pcw = 1'b0; rw = 1'b0; mw = 1'b0; ill = 1'b0;
      if (bus.op == 7'b0100011)      imm = 2'b01;
      else if (bus.op == 7'b1100011) imm = 2'b10;
      else if (bus.op == 7'b1101111) imm = 2'b11;
      case (st)
         S_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
         S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
         S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
         S_MEMREAD:  adr = 1'b1;
         S_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
         S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
         S_EXECUTER: begin sa = 2'b10; alu = exp_alu(bus.funct3, bus.op[5], bus.funct7b5); end
         S_EXECUTEI: begin sa = 2'b10; sb = 2'b01; alu = exp_alu(bus.funct3, bus.op[5], bus.funct7b5); end
         S_ALUWB:    rw = 1'b1;
         S_BEQ: begin
            sa  = 2'b10;
            alu = 3'b001;
            if (bus.funct3 == 3'b000)      pcw = bus.zero;
            else if (bus.funct3 == 3'b001) pcw = !bus.zero;
         end
         S_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
         S_ILLEGAL:  ill = 1'b1;
         default:    ;
      endcase
      if (!rst_ok) begin irw = 1'b0; pcw = 1'b0; rw = 1'b0; mw = 1'b0; ill = 1'b0; end
      return {st, imm, sa, sb, rs, adr, alu, irw, pcw, rw, mw, ill};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string tag);
      logic [20:0] exp_v, obs_v;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed empty queue, expected an entry", tag);
         return;
      end
      exp_v = exp_q.pop_front();
      obs_v = {bus.state_dbg, bus.immsrc, bus.alusrca, bus.alusrcb, bus.resultsrc, bus.adrsrc,
               bus.alucontrol, bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite, bus.illegal};
      assert (obs_v === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input state_t st, input logic mr, input string tag);
      bus.mem_ready = mr;
      exp_q.push_back(model(st, mr, 1'b1));
      @(negedge clk);
      check(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
      bus.op       = op;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
      bus.zero     = z;
   endtask

   // ---------------- directed sequence ----------------
   logic [2:0] f3_tab [5];
   int         waits;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      f3_tab   = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b100};
      rst_n    = 1'b0;
      set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      bus.mem_ready = 1'b1;

      // Reset holds FETCH with enables masked even though mem_ready=1
      exp_q.push_back(model(S_FETCH, 1'b1, 1'b0));
      @(negedge clk);
      check("reset_hold");
      bus.mem_ready = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      step(S_FETCH, 1'b0, "post_reset_fetch");

      // add / sub
      set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
      step(S_FETCH, 1'b1, "add_fetch");
      step(S_DECODE, 1'b1, "add_decode");
      step(S_EXECUTER, 1'b1, "add_exec");
      step(S_ALUWB, 1'b1, "add_wb");
      set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
      step(S_FETCH, 1'b1, "sub_fetch");
      step(S_DECODE, 1'b1, "sub_decode");
      step(S_EXECUTER, 1'b1, "sub_exec");
      step(S_ALUWB, 1'b1, "sub_wb");

      // lw with three wait cycles in MEMREAD
      set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      step(S_FETCH, 1'b1, "lw_fetch");
      step(S_DECODE, 1'b1, "lw_decode");
      step(S_MEMADR, 1'b1, "lw_memadr");
      step(S_MEMREAD, 1'b0, "lw_wait0");
      step(S_MEMREAD, 1'b0, "lw_wait1");
      step(S_MEMREAD, 1'b0, "lw_wait2");
      step(S_MEMREAD, 1'b1, "lw_memread");
      step(S_MEMWB, 1'b1, "lw_memwb");

      // sw
      set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      step(S_FETCH, 1'b1, "sw_fetch");
      step(S_DECODE, 1'b1, "sw_decode");
      step(S_MEMADR, 1'b1, "sw_memadr");
      step(S_MEMWRITE, 1'b1, "sw_memwrite");

      // beq taken, bne not taken, bne taken, unsupported branch funct3
      set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
      step(S_FETCH, 1'b1, "beq_fetch");
      step(S_DECODE, 1'b1, "beq_decode");
      step(S_BEQ, 1'b1, "beq_taken");
      set_instr(7'b1100011, 3'b001, 1'b0, 1'b1);
      step(S_FETCH, 1'b1, "bne_fetch");
      step(S_DECODE, 1'b1, "bne_decode");
      step(S_BEQ, 1'b1, "bne_not_taken");
      set_instr(7'b1100011, 3'b001, 1'b0, 1'b0);
      step(S_FETCH, 1'b1, "bne2_fetch");
      step(S_DECODE, 1'b1, "bne2_decode");
      step(S_BEQ, 1'b1, "bne_taken");
      set_instr(7'b1100011, 3'b100, 1'b0, 1'b1);
      step(S_FETCH, 1'b1, "blt_fetch");
      step(S_DECODE, 1'b1, "blt_decode");
      step(S_BEQ, 1'b1, "blt_no_pcwrite");

      // jal
      set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
      step(S_FETCH, 1'b1, "jal_fetch");
      step(S_DECODE, 1'b1, "jal_decode");
      step(S_JAL, 1'b1, "jal_jal");
      step(S_ALUWB, 1'b1, "jal_wb");

      // unknown opcode traps for one cycle
      set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
      step(S_FETCH, 1'b1, "ill_fetch");
      step(S_DECODE, 1'b1, "ill_decode");
      step(S_ILLEGAL, 1'b1, "ill_pulse");
      step(S_FETCH, 1'b0, "ill_back_fetch");

      // I-type ALU with random funct3 / funct7b5 (never subtracts)
      for (int i = 0; i < 5; i++) begin
         set_instr(7'b0010011, f3_tab[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 1'b0);
         step(S_FETCH, 1'b1, "iop_fetch");
         step(S_DECODE, 1'b1, "iop_decode");
         step(S_EXECUTEI, 1'b1, "iop_exec");
         step(S_ALUWB, 1'b1, "iop_wb");
      end

      // R-type with random funct fields
      for (int i = 0; i < 4; i++) begin
         set_instr(7'b0110011, f3_tab[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 1'b0);
         step(S_FETCH, 1'b1, "rop_fetch");
         step(S_DECODE, 1'b1, "rop_decode");
         step(S_EXECUTER, 1'b1, "rop_exec");
         step(S_ALUWB, 1'b1, "rop_wb");
      end

      // lw with random fetch and memory waits
      set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      waits = $urandom_range(0, 3);
      for (int i = 0; i < waits; i++) step(S_FETCH, 1'b0, "lwr_fetch_wait");
      step(S_FETCH, 1'b1, "lwr_fetch");
      step(S_DECODE, 1'b1, "lwr_decode");
      step(S_MEMADR, 1'b1, "lwr_memadr");
      waits = $urandom_range(0, 3);
      for (int i = 0; i < waits; i++) step(S_MEMREAD, 1'b0, "lwr_mem_wait");
      step(S_MEMREAD, 1'b1, "lwr_memread");
      step(S_MEMWB, 1'b1, "lwr_memwb");

      // asynchronous reset in the middle of a stalled store
      set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      step(S_FETCH, 1'b1, "swr_fetch");
      step(S_DECODE, 1'b1, "swr_decode");
      step(S_MEMADR, 1'b1, "swr_memadr");
      step(S_MEMWRITE, 1'b0, "swr_stall");
      #2 rst_n = 1'b0;
      #1;
      exp_q.push_back(model(S_FETCH, 1'b0, 1'b0));
      check("swr_async_reset");
      @(posedge clk); #2 rst_n = 1'b1;
      step(S_FETCH, 1'b0, "swr_post_reset");
      step(S_FETCH, 1'b1, "swr2_fetch");
      step(S_DECODE, 1'b1, "swr2_decode");
      step(S_MEMADR, 1'b1, "swr2_memadr");
      step(S_MEMWRITE, 1'b1, "swr2_memwrite");
      step(S_FETCH, 1'b0, "swr2_done");

      n_checks++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL queue_drain: observed %0d entries expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
